seq_div_unit: RTL

Iterative 32-bit signed/unsigned divider. It is the responder side of the execute stage's divide handshake: the stage presents operands with `div_in_valid` and stalls until the unit returns `{remainder, quotient}` with `div_out_valid`, then writes HI/LO. The unit is a radix-2 restoring divider with one iteration per cycle, a pipeline flush input, and a valid/ready output handshake.

---
 rtl/seq_div_unit.sv | 117 +++++++++++
 1 files changed

// File: rtl/seq_div_unit.sv
// Radix-2 restoring divider, one quotient bit per cycle, with flush and a
// valid/ready result handshake. Result is {remainder, quotient}.
module seq_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               flush,
  input  logic [1:0]         div_op,
  input  logic [WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]   divisor,
  input  logic               div_in_valid,
  output logic               div_in_ready,
  output logic [2*WIDTH-1:0] div_result,
  output logic               div_out_valid,
  input  logic               div_out_ready
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] rem_reg;
  logic [WIDTH-1:0] quo_reg;
  logic [WIDTH-1:0] dsr_reg;
  logic             sign_q_reg;
  logic             sign_r_reg;
  logic [CW-1:0]    iter_reg;

  logic             op_signed;
  logic             request;
  logic             sign_q_next;
  logic             sign_r_next;
  logic [WIDTH-1:0] abs_dividend;
  logic [WIDTH-1:0] abs_divisor;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;
  logic [WIDTH-1:0] rem_fix;
  logic [WIDTH-1:0] quo_fix;
  logic             last_step;

  always_comb begin
    op_signed    = div_op[0];
    request      = div_in_valid & (div_op != 2'b00);
    sign_q_next  = op_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
    sign_r_next  = op_signed & dividend[WIDTH-1];
    abs_dividend = (op_signed & dividend[WIDTH-1]) ? -dividend : dividend;
    abs_divisor  = (op_signed & divisor[WIDTH-1])  ? -divisor  : divisor;
    // The partial remainder never exceeds WIDTH bits, so only its low part is stored.
    trial        = {rem_reg, quo_reg[WIDTH-1]};
    diff         = trial - {1'b0, dsr_reg};
    rem_next     = diff[WIDTH] ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
    quo_next     = {quo_reg[WIDTH-2:0], ~diff[WIDTH]};
    rem_fix      = sign_r_reg ? -rem_next : rem_next;
    quo_fix      = sign_q_reg ? -quo_next : quo_next;
    last_step    = (iter_reg == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg     <= IDLE;
      rem_reg       <= '0;
      quo_reg       <= '0;
      dsr_reg       <= '0;
      sign_q_reg    <= 1'b0;
      sign_r_reg    <= 1'b0;
      iter_reg      <= '0;
      div_in_ready  <= 1'b1;
      div_out_valid <= 1'b0;
      div_result    <= '0;
    end else if (flush) begin
      state_reg     <= IDLE;
      div_in_ready  <= 1'b1;
      div_out_valid <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (request) begin
            quo_reg      <= abs_dividend;
            dsr_reg      <= abs_divisor;
            rem_reg      <= '0;
            sign_q_reg   <= sign_q_next;
            sign_r_reg   <= sign_r_next;
            iter_reg     <= '0;
            div_in_ready <= 1'b0;
            state_reg    <= CALC;
          end
        end
        CALC: begin
          rem_reg  <= rem_next;
          quo_reg  <= quo_next;
          iter_reg <= iter_reg + 1'b1;
          // Sign correction is folded into the final step so the output is registered.
          if (last_step) begin
            div_result    <= {rem_fix, quo_fix};
            div_out_valid <= 1'b1;
            state_reg     <= DONE;
          end
        end
        DONE: begin
          if (div_out_ready) begin
            div_out_valid <= 1'b0;
            div_in_ready  <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule
